// File: rtl/udm_uart_pkg.sv
// rtl/udm_uart_pkg.sv - shared types and constants for the UDM UART blocks
package udm_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;

  // Frame length in clock cycles; dividers below 2 run as 2.
  function automatic int unsigned uart_frame_cycles(
    input int unsigned div,
    input logic        parity_en,
    input logic        stop2
  );
    int unsigned d;
    d = (div < 32'd2) ? 32'd2 : div;
    return d * (UART_DATA_BITS + 32'd2 + {31'd0, parity_en} + {31'd0, stop2});
  endfunction

endpackage

// File: rtl/udm_sync_fifo.sv
// rtl/udm_sync_fifo.sv - synchronous FIFO shared by the UDM UART transmitter and receiver
module udm_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             srst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // One extra pointer bit tells full from empty when the index bits match.
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full_o     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty_o    = (r_wptr == r_rptr);
  assign w_push_ok  = push_i && !full_o;
  assign w_pop_ok   = pop_i && !empty_o;
  assign pop_data_o = r_mem[r_rptr[AW-1:0]];

  // Pointer update; a push against a full FIFO is ignored even if a pop frees a slot this cycle.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop_ok)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/udm_uart_tx.sv
// rtl/udm_uart_tx.sv - UART transmit engine with byte FIFO for the UDM return path
module udm_uart_tx
  import udm_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic             clk_i,
  input  logic             srst_n_i,
  input  logic [DIV_W-1:0] divider_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  input  logic             stop2_i,
  input  logic             wr_i,
  input  logic [7:0]       wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             busy_o,
  output logic             ovf_o,
  output logic             tx_o
);

  localparam logic [DIV_W-1:0] DIV_ONE = 1;
  localparam logic [DIV_W-1:0] DIV_TWO = 2;

  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic             w_pop;
  logic             w_tx_bit;
  logic             w_bit_end;
  logic [DIV_W-1:0] w_div_in;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_timer;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitcnt;
  logic             r_par_en;
  logic             r_par_bit;
  logic             r_stop2;
  logic             r_stop_cnt;
  logic [7:0]       w_fifo_rdata;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             r_tx;
  logic             r_busy;
  logic             r_ovf;

  udm_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i       (clk_i),
    .srst_n_i    (srst_n_i),
    .push_i      (wr_i),
    .push_data_i (wdata_i),
    .pop_i       (w_pop),
    .pop_data_o  (w_fifo_rdata),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty)
  );

  assign w_div_in  = (divider_i < DIV_TWO) ? DIV_TWO : divider_i;
  assign w_bit_end = (r_timer == '0);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state, FIFO pop and the line level of the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_bit    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_tx_bit = 1'b0;
        if (w_bit_end) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_tx_bit = r_shift[0];
        if (w_bit_end && (r_bitcnt == 3'(UART_DATA_BITS - 1))) begin
          w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        w_tx_bit = r_par_bit;
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        w_tx_bit = 1'b1;
        if (w_bit_end && (!r_stop2 || r_stop_cnt)) begin
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame datapath: a pop latches byte and format; otherwise the bit timer runs and shifts data.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      r_div      <= DIV_TWO;
      r_timer    <= '0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
    end else if (w_pop) begin
      r_div      <= w_div_in;
      r_timer    <= w_div_in - DIV_ONE;
      r_shift    <= w_fifo_rdata;
      r_bitcnt   <= '0;
      r_par_en   <= parity_en_i;
      r_par_bit  <= (^w_fifo_rdata) ^ parity_odd_i;
      r_stop2    <= stop2_i;
      r_stop_cnt <= 1'b0;
    end else if (r_state != ST_IDLE) begin
      if (w_bit_end) begin
        r_timer <= r_div - DIV_ONE;
        if (r_state == ST_DATA) begin
          r_shift  <= {1'b0, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        if (r_state == ST_STOP) r_stop_cnt <= 1'b1;
      end else begin
        r_timer <= r_timer - DIV_ONE;
      end
    end
  end

  // Line and busy are registered from the current state, so both trail the FSM by one cycle.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_tx   <= w_tx_bit;
      r_busy <= (r_state != ST_IDLE);
      r_ovf  <= wr_i && w_fifo_full;
    end
  end

  assign tx_o    = r_tx;
  assign busy_o  = r_busy;
  assign ovf_o   = r_ovf;
  assign full_o  = w_fifo_full;
  assign empty_o = w_fifo_empty;

endmodule
